pwm_die_monitor: RTL and testbench

Receive-side checker for a complementary dead-time PWM pair (channel A, channel B) driven by the team's half-bridge pulse generator.

---
 rtl/pwm_mon_pkg.sv | 20 ++
 rtl/pwm_die_monitor_if.sv | 24 ++
 rtl/pwm_die_monitor_edge_det.sv | 30 +++
 rtl/pwm_die_monitor.sv | 196 +++++++++++++++++++
 tb/tb_pwm_die_monitor.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_mon_pkg.sv
// Shared types and helpers for the PWM dead-time monitor.
// Holds the FSM state encoding, default counter width and saturation limit.
package pwm_mon_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_A_ON    = 2'd1,
        ST_DEAD_AB = 2'd2,
        ST_B_ON    = 2'd3
    } state_e;

    function automatic logic [63:0] sat_limit(input int unsigned w);
        if (w >= 64)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_die_monitor_if.sv
// Result bus of the PWM dead-time monitor: measurements and sticky flags.
// The monitor drives it through master; consumers read it through slave.
interface pwm_die_monitor_if #(
    parameter int W = 32
);
    logic         meas_valid;
    logic [W-1:0] width_a;
    logic [W-1:0] dead_ab;
    logic [W-1:0] width_b;
    logic         err_overlap;
    logic         err_order;
    logic         err_dead_short;
    logic         err_timeout;

    modport master (
        output meas_valid, width_a, dead_ab, width_b,
        output err_overlap, err_order, err_dead_short, err_timeout
    );

    modport slave (
        input meas_valid, width_a, dead_ab, width_b,
        input err_overlap, err_order, err_dead_short, err_timeout
    );
endinterface

// File: rtl/pwm_die_monitor_edge_det.sv
// Per-channel front end: registers the pin, normalizes it against the idle
// level and compares with a delayed copy to produce act/rise/fall.
module pwm_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    input  logic def_level_i,
    output logic act_o,
    output logic rise_o,
    output logic fall_o
);

    logic act_q;
    logic dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            act_q <= level_i ^ def_level_i;
            dly_q <= act_q;
        end
    end

    assign act_o  = act_q;
    assign rise_o = act_q & ~dly_q;
    assign fall_o = ~act_q & dly_q;

endmodule

// File: rtl/pwm_die_monitor.sv
// Receive-side checker for a complementary dead-time PWM pair (A, B).
// Optional watchdog enabled by defining PWM_MON_TIMEOUT_EN.
module pwm_die_monitor
    import pwm_mon_pkg::*;
#(
    parameter int          _RAM_WIDTH     = DEF_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_en,
    input  logic                  io_defaultLevel,
    input  logic                  io_pulseIn_a,
    input  logic                  io_pulseIn_b,
    input  logic [_RAM_WIDTH-1:0] die_min,
    input  logic                  err_clr,
    pwm_die_monitor_if.master     mon
);

    localparam logic [_RAM_WIDTH-1:0] CNT_MAX =
        _RAM_WIDTH'(sat_limit(_RAM_WIDTH));

    logic a_act, a_rise, a_fall;
    logic b_act, b_rise, b_fall;

    pwm_edge_det u_edge_a (
        .clk_i       (io_clk),
        .rst_i       (io_rst),
        .level_i     (io_pulseIn_a),
        .def_level_i (io_defaultLevel),
        .act_o       (a_act),
        .rise_o      (a_rise),
        .fall_o      (a_fall)
    );

    pwm_edge_det u_edge_b (
        .clk_i       (io_clk),
        .rst_i       (io_rst),
        .level_i     (io_pulseIn_b),
        .def_level_i (io_defaultLevel),
        .act_o       (b_act),
        .rise_o      (b_rise),
        .fall_o      (b_fall)
    );

    state_e                  state_q, state_d;
    logic [_RAM_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [_RAM_WIDTH-1:0]   wa_r_q, wa_r_d;
    logic [_RAM_WIDTH-1:0]   dd_r_q, dd_r_d;
    logic [_RAM_WIDTH-1:0]   wa_q, dd_q, wb_q;
    logic                    valid_q;
    logic                    ovl_q, ord_q, short_q;
    logic                    done, set_ovl, set_ord, set_short, set_to;

`ifdef PWM_MON_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        to_q;
`endif

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wa_r_d    = wa_r_q;
        dd_r_d    = dd_r_q;
        done      = 1'b0;
        set_ovl   = 1'b0;
        set_ord   = 1'b0;
        set_short = 1'b0;
        set_to    = 1'b0;
        if (!io_en) begin
            state_d = ST_IDLE;
        end else if (a_act && b_act) begin
            set_ovl = 1'b1;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (a_rise) begin
                        state_d = ST_A_ON;
                        cnt_d   = 1;
                    end else if (b_rise) begin
                        set_ord = 1'b1;
                    end
                end
                ST_A_ON: begin
                    if (b_rise) begin
                        set_ord = 1'b1;
                        state_d = ST_IDLE;
                    end else if (a_fall) begin
                        wa_r_d  = cnt_q;
                        state_d = ST_DEAD_AB;
                        cnt_d   = 1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DEAD_AB: begin
                    if (b_rise) begin
                        dd_r_d  = cnt_q;
                        state_d = ST_B_ON;
                        cnt_d   = 1;
                    end else if (a_rise) begin
                        set_ord = 1'b1;
                        state_d = ST_A_ON;
                        cnt_d   = 1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_B_ON: begin
                    if (b_fall) begin
                        done      = 1'b1;
                        set_short = (dd_r_q < die_min);
                        // A may already be starting the next period
                        state_d   = a_rise ? ST_A_ON : ST_IDLE;
                        cnt_d     = 1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef PWM_MON_TIMEOUT_EN
            if (state_q != ST_IDLE && state_d == state_q &&
                wd_q == TIMEOUT_CYCLES - 1) begin
                set_to  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
        end
    end

`ifdef PWM_MON_TIMEOUT_EN
    always_comb begin
        wd_d = wd_q + 32'd1;
        if (state_q == ST_IDLE || state_d != state_q)
            wd_d = '0;
    end
`endif

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wa_r_q  <= '0;
            dd_r_q  <= '0;
            wa_q    <= '0;
            dd_q    <= '0;
            wb_q    <= '0;
            valid_q <= 1'b0;
            ovl_q   <= 1'b0;
            ord_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wa_r_q  <= wa_r_d;
            dd_r_q  <= dd_r_d;
            valid_q <= done;
            if (done) begin
                wa_q <= wa_r_q;
                dd_q <= dd_r_q;
                wb_q <= cnt_q;
            end
            ovl_q   <= set_ovl   | (ovl_q   & ~err_clr);
            ord_q   <= set_ord   | (ord_q   & ~err_clr);
            short_q <= set_short | (short_q & ~err_clr);
        end
    end

`ifdef PWM_MON_TIMEOUT_EN
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= set_to | (to_q & ~err_clr);
        end
    end
    assign mon.err_timeout = to_q;
`else
    assign mon.err_timeout = set_to;
`endif

    assign mon.meas_valid     = valid_q;
    assign mon.width_a        = wa_q;
    assign mon.dead_ab        = dd_q;
    assign mon.width_b        = wb_q;
    assign mon.err_overlap    = ovl_q;
    assign mon.err_order      = ord_q;
    assign mon.err_dead_short = short_q;

endmodule

// File: tb/tb_pwm_die_monitor.sv
// Scoreboard bench for pwm_die_monitor: expected pulse measurements are
// queued as stimulus is driven and compared when meas_valid fires.
module tb_pwm_die_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dl;
    logic        pa;
    logic        pb;
    logic [31:0] die_min;
    logic        err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int unsigned wa;
        int unsigned dd;
        int unsigned wb;
    } exp_t;

    exp_t sb[$];

    pwm_die_monitor_if #(.W(32)) mon_if ();

    pwm_die_monitor #(
        ._RAM_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .io_clk          (clk),
        .io_rst          (rst),
        .io_en           (en),
        .io_defaultLevel (dl),
        .io_pulseIn_a    (pa),
        .io_pulseIn_b    (pb),
        .die_min         (die_min),
        .err_clr         (err_clr),
        .mon             (mon_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_if.meas_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("width_a", mon_if.width_a, e.wa);
                check("dead_ab", mon_if.dead_ab, e.dd);
                check("width_b", mon_if.width_b, e.wb);
            end
        end
    end

    // a, b are active levels; physical pins follow the idle level
    task automatic drive(input logic a, input logic b, input int n);
        pa = a ^ dl;
        pb = b ^ dl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pair(input int wa, input int dd, input int wb);
        exp_t e;
        e.wa = wa;
        e.dd = dd;
        e.wb = wb;
        sb.push_back(e);
        drive(1'b1, 1'b0, wa);
        drive(1'b0, 1'b0, dd);
        drive(1'b0, 1'b1, wb);
        drive(1'b0, 1'b0, 3);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic flags(input logic o, input logic r, input logic s);
        check("err_overlap", mon_if.err_overlap, o);
        check("err_order", mon_if.err_order, r);
        check("err_dead_short", mon_if.err_dead_short, s);
    endtask

    task automatic clear();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic zero_outputs(input string tag);
        check({tag, "_valid"}, mon_if.meas_valid, 0);
        check({tag, "_width_a"}, mon_if.width_a, 0);
        check({tag, "_dead_ab"}, mon_if.dead_ab, 0);
        check({tag, "_width_b"}, mon_if.width_b, 0);
        check({tag, "_overlap"}, mon_if.err_overlap, 0);
        check({tag, "_order"}, mon_if.err_order, 0);
        check({tag, "_short"}, mon_if.err_dead_short, 0);
        check({tag, "_timeout"}, mon_if.err_timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        dl      = 1'b0;
        pa      = 1'b0;
        pb      = 1'b0;
        die_min = 32'd3;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        zero_outputs("reset");
        rst = 1'b0;
        en  = 1'b1;
        drive(1'b0, 1'b0, 3);

        // 1: nominal pair, dead time exactly at minimum
        pair(5, 3, 5);
        drain();
        flags(1'b0, 1'b0, 1'b0);

        // 2: dead time one short of minimum
        die_min = 32'd4;
        pair(5, 3, 5);
        drain();
        flags(1'b0, 1'b0, 1'b1);
        clear();
        flags(1'b0, 1'b0, 1'b0);
        die_min = 32'd0;

        // 3: shoot-through aborts, then a clean pair
        drive(1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 4);
        flags(1'b1, 1'b0, 1'b0);
        pair(4, 2, 3);
        drain();
        clear();
        flags(1'b0, 1'b0, 1'b0);

        // 4: active-low channels
        en = 1'b0;
        dl = 1'b1;
        drive(1'b0, 1'b0, 3);
        en = 1'b1;
        drive(1'b0, 1'b0, 2);
        pair(7, 2, 6);
        drain();
        flags(1'b0, 1'b0, 1'b0);

        // 5a: B without a preceding A
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 3);
        flags(1'b0, 1'b1, 1'b0);
        clear();
        flags(1'b0, 1'b0, 1'b0);

        // 5b: enable dropped mid-B_ON
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 2);
        en = 1'b0;
        drive(1'b0, 1'b1, 2);
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        flags(1'b0, 1'b0, 1'b0);
        check("width_a_held", mon_if.width_a, 7);

        // 5c: reset during A_ON with a sticky flag set
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 3);
        check("order_before_rst", mon_if.err_order, 1);
        drive(1'b1, 1'b0, 3);
        rst = 1'b1;
        pa  = dl;
        @(posedge clk);
        #1;
        zero_outputs("midrst");
        rst = 1'b0;
        drive(1'b0, 1'b0, 3);

        // minimum dead time of one clock
        pair(3, 1, 2);
        drain();
        flags(1'b0, 1'b0, 1'b0);

        // 6: A held active for 20 clocks
        drive(1'b1, 1'b0, 20);
`ifdef PWM_MON_TIMEOUT_EN
        check("err_timeout", mon_if.err_timeout, 1);
`else
        check("err_timeout", mon_if.err_timeout, 0);
`endif
        drive(1'b0, 1'b0, 3);
        en = 1'b0;
        drive(1'b0, 1'b0, 2);
        en = 1'b1;
        drive(1'b0, 1'b0, 2);
        check("sb_empty_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
